// File: rtl/svc_axi_pkg.sv
// Shared AXI definitions: response encodings used by the AXI/AXI-Lite slave blocks.
package svc_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/svc_axil_sram_wr.sv
// AXI-Lite write slave that turns AW/W pairs into single-word SRAM write commands.
// Define SVC_AXIL_SRAM_WR_RANGE_CHECK_EN to answer out-of-range word addresses with SLVERR.
module svc_axil_sram_wr
  import svc_axi_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 8,
  parameter int AXIL_DATA_WIDTH = 16,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
  parameter int MEM_DEPTH       = 2 ** (AXIL_ADDR_WIDTH - $clog2(AXIL_STRB_WIDTH))
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    s_axil_awvalid,
  input  logic [AXIL_ADDR_WIDTH-1:0]                              s_axil_awaddr,
  output logic                                                    s_axil_awready,
  input  logic                                                    s_axil_wvalid,
  input  logic [AXIL_DATA_WIDTH-1:0]                              s_axil_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0]                              s_axil_wstrb,
  output logic                                                    s_axil_wready,
  output logic                                                    s_axil_bvalid,
  output logic [1:0]                                              s_axil_bresp,
  input  logic                                                    s_axil_bready,
  output logic                                                    sram_wr_cmd_valid,
  input  logic                                                    sram_wr_cmd_ready,
  output logic [AXIL_ADDR_WIDTH-$clog2(AXIL_STRB_WIDTH)-1:0]      sram_wr_cmd_addr,
  output logic [AXIL_DATA_WIDTH-1:0]                              sram_wr_cmd_data,
  output logic [AXIL_STRB_WIDTH-1:0]                              sram_wr_cmd_strb
);

  localparam int LSB    = $clog2(AXIL_STRB_WIDTH);
  localparam int MEM_AW = AXIL_ADDR_WIDTH - LSB;

  logic                       aw_full;
  logic                       w_full;
  logic [MEM_AW-1:0]          aw_addr_p0;
  logic [AXIL_DATA_WIDTH-1:0] w_data_p0;
  logic [AXIL_STRB_WIDTH-1:0] w_strb_p0;
  logic                       aw_hs;
  logic                       w_hs;
  logic                       cmd_hs;
  logic                       load;
  logic                       out_of_range;

  assign s_axil_awready = !aw_full;
  assign s_axil_wready  = !w_full;
  assign aw_hs          = s_axil_awvalid && s_axil_awready;
  assign w_hs           = s_axil_wvalid && s_axil_wready;
  assign cmd_hs         = sram_wr_cmd_valid && sram_wr_cmd_ready;
  // One transaction in flight past the entries: command and B stage must both be free.
  assign load           = aw_full && w_full && !sram_wr_cmd_valid &&
                          (!s_axil_bvalid || s_axil_bready);

`ifdef SVC_AXIL_SRAM_WR_RANGE_CHECK_EN
  localparam logic [MEM_AW:0] DEPTH_LIM = (MEM_AW + 1)'(MEM_DEPTH);
  assign out_of_range = {1'b0, aw_addr_p0} >= DEPTH_LIM;
`else
  localparam int unused_mem_depth = MEM_DEPTH;
  assign out_of_range = 1'b0;
`endif

  if (LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^s_axil_awaddr[LSB-1:0];
  end

  // Stage 0: hold entries (payload only, qualified by the full flags)
  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_p0 <= s_axil_awaddr[AXIL_ADDR_WIDTH-1:LSB];
    if (w_hs) begin
      w_data_p0 <= s_axil_wdata;
      w_strb_p0 <= s_axil_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full           <= 1'b0;
      w_full            <= 1'b0;
      sram_wr_cmd_valid <= 1'b0;
      sram_wr_cmd_addr  <= '0;
      sram_wr_cmd_data  <= '0;
      sram_wr_cmd_strb  <= '0;
      s_axil_bvalid     <= 1'b0;
      s_axil_bresp      <= AXI_RESP_OKAY;
    end else begin
      if (load)       aw_full <= 1'b0;
      else if (aw_hs) aw_full <= 1'b1;
      if (load)      w_full <= 1'b0;
      else if (w_hs) w_full <= 1'b1;

      // Stage 1: SRAM command
      if (load && !out_of_range) begin
        sram_wr_cmd_valid <= 1'b1;
        sram_wr_cmd_addr  <= aw_addr_p0;
        sram_wr_cmd_data  <= w_data_p0;
        sram_wr_cmd_strb  <= w_strb_p0;
      end else if (cmd_hs) begin
        sram_wr_cmd_valid <= 1'b0;
      end

      // Stage 2: B response
      if (cmd_hs) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= AXI_RESP_OKAY;
      end else if (load && out_of_range) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= AXI_RESP_SLVERR;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_svc_axil_sram_wr.sv
// Self-checking bench for svc_axil_sram_wr: directed scenarios plus a randomized scoreboard run.
module tb_svc_axil_sram_wr;

`ifdef SVC_AXIL_SRAM_WR_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  localparam int DEPTH = 64;
  localparam int NRAND = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axil_awvalid = 1'b0;
  logic [7:0]  s_axil_awaddr = '0;
  logic        s_axil_awready;
  logic        s_axil_wvalid = 1'b0;
  logic [15:0] s_axil_wdata = '0;
  logic [1:0]  s_axil_wstrb = '0;
  logic        s_axil_wready;
  logic        s_axil_bvalid;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bready = 1'b1;
  logic        sram_wr_cmd_valid;
  logic        sram_wr_cmd_ready = 1'b1;
  logic [6:0]  sram_wr_cmd_addr;
  logic [15:0] sram_wr_cmd_data;
  logic [1:0]  sram_wr_cmd_strb;

  int total = 0;
  int bad = 0;

  svc_axil_sram_wr #(
    .AXIL_ADDR_WIDTH(8),
    .AXIL_DATA_WIDTH(16),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awaddr(s_axil_awaddr),
    .s_axil_awready(s_axil_awready),
    .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wdata(s_axil_wdata),
    .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wready(s_axil_wready),
    .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bresp(s_axil_bresp),
    .s_axil_bready(s_axil_bready),
    .sram_wr_cmd_valid(sram_wr_cmd_valid),
    .sram_wr_cmd_ready(sram_wr_cmd_ready),
    .sram_wr_cmd_addr(sram_wr_cmd_addr),
    .sram_wr_cmd_data(sram_wr_cmd_data),
    .sram_wr_cmd_strb(sram_wr_cmd_strb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_both(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s);
    s_axil_awvalid = 1'b1; s_axil_awaddr = a;
    s_axil_wvalid = 1'b1;  s_axil_wdata = d; s_axil_wstrb = s;
  endtask

  task automatic clear_valids();
    s_axil_awvalid = 1'b0;
    s_axil_wvalid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++;
    if ({s_axil_awready, s_axil_wready, sram_wr_cmd_valid, s_axil_bvalid, s_axil_bresp} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_ctrl: got aw/w/cmd/b/resp=%b want 110000",
               {s_axil_awready, s_axil_wready, sram_wr_cmd_valid, s_axil_bvalid, s_axil_bresp});
    end
    total++;
    if ({sram_wr_cmd_addr, sram_wr_cmd_data, sram_wr_cmd_strb} !== 25'd0) begin
      bad++;
      $display("FAIL reset_payload: got addr=%h data=%h strb=%b want zeros",
               sram_wr_cmd_addr, sram_wr_cmd_data, sram_wr_cmd_strb);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    sram_wr_cmd_ready = 1'b1; s_axil_bready = 1'b1;
    send_both(8'h04, 16'hBEEF, 2'b11);
    tick();
    clear_valids();
    total++;
    if (s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0 || sram_wr_cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL same_n1: awready=%b wready=%b cmd_valid=%b want 0 0 0",
               s_axil_awready, s_axil_wready, sram_wr_cmd_valid);
    end
    tick();
    total++;
    if (sram_wr_cmd_valid !== 1'b1 || sram_wr_cmd_addr !== 7'h02 || sram_wr_cmd_data !== 16'hBEEF ||
        sram_wr_cmd_strb !== 2'b11 || s_axil_bvalid !== 1'b0) begin
      bad++;
      $display("FAIL same_n2: v=%b addr=%h data=%h strb=%b bvalid=%b want 1 02 beef 11 0",
               sram_wr_cmd_valid, sram_wr_cmd_addr, sram_wr_cmd_data, sram_wr_cmd_strb, s_axil_bvalid);
    end
    tick();
    total++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || sram_wr_cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL same_n3: bvalid=%b bresp=%b cmd_valid=%b want 1 00 0",
               s_axil_bvalid, s_axil_bresp, sram_wr_cmd_valid);
    end
    tick();
    total++;
    if (s_axil_bvalid !== 1'b0) begin
      bad++;
      $display("FAIL same_b_drop: bvalid=%b want 0", s_axil_bvalid);
    end
  endtask

  task automatic test_w_first();
    s_axil_wvalid = 1'b1; s_axil_wdata = 16'h5A5A; s_axil_wstrb = 2'b10;
    tick();
    s_axil_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (s_axil_wready !== 1'b0 || s_axil_awready !== 1'b1 || sram_wr_cmd_valid !== 1'b0) begin
        bad++;
        $display("FAIL wfirst_hold%0d: wready=%b awready=%b cmd_valid=%b want 0 1 0",
                 i, s_axil_wready, s_axil_awready, sram_wr_cmd_valid);
      end
      if (i < 2) tick();
    end
    s_axil_awvalid = 1'b1; s_axil_awaddr = 8'h10;
    tick();
    s_axil_awvalid = 1'b0;
    tick();
    total++;
    if (sram_wr_cmd_valid !== 1'b1 || sram_wr_cmd_addr !== 7'h08 || sram_wr_cmd_data !== 16'h5A5A ||
        sram_wr_cmd_strb !== 2'b10) begin
      bad++;
      $display("FAIL wfirst_cmd: v=%b addr=%h data=%h strb=%b want 1 08 5a5a 10",
               sram_wr_cmd_valid, sram_wr_cmd_addr, sram_wr_cmd_data, sram_wr_cmd_strb);
    end
    tick(); tick();
  endtask

  task automatic test_cmd_stall();
    sram_wr_cmd_ready = 1'b0; s_axil_bready = 1'b1;
    send_both(8'h2A, 16'h1234, 2'b00);
    tick();
    clear_valids();
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sram_wr_cmd_valid !== 1'b1 || sram_wr_cmd_addr !== 7'h15 || sram_wr_cmd_data !== 16'h1234 ||
          sram_wr_cmd_strb !== 2'b00 || s_axil_bvalid !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: v=%b addr=%h data=%h strb=%b bvalid=%b want 1 15 1234 00 0",
                 i, sram_wr_cmd_valid, sram_wr_cmd_addr, sram_wr_cmd_data, sram_wr_cmd_strb, s_axil_bvalid);
      end
      tick();
    end
    sram_wr_cmd_ready = 1'b1;
    tick();
    total++;
    if (sram_wr_cmd_valid !== 1'b0 || s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
      bad++;
      $display("FAIL stall_release: cmd_valid=%b bvalid=%b bresp=%b want 0 1 00",
               sram_wr_cmd_valid, s_axil_bvalid, s_axil_bresp);
    end
    tick();
  endtask

  task automatic test_b_stall();
    sram_wr_cmd_ready = 1'b1; s_axil_bready = 1'b0;
    send_both(8'h06, 16'hAAAA, 2'b01);
    tick();
    clear_valids();
    tick();
    send_both(8'h0E, 16'hBBBB, 2'b11);
    tick();
    clear_valids();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sram_wr_cmd_valid !== 1'b0 || s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 ||
          s_axil_awready !== 1'b0) begin
        bad++;
        $display("FAIL bstall_hold%0d: cmd_valid=%b bvalid=%b bresp=%b awready=%b want 0 1 00 0",
                 i, sram_wr_cmd_valid, s_axil_bvalid, s_axil_bresp, s_axil_awready);
      end
      tick();
    end
    s_axil_bready = 1'b1;
    tick();
    total++;
    if (sram_wr_cmd_valid !== 1'b1 || sram_wr_cmd_addr !== 7'h07 || sram_wr_cmd_data !== 16'hBBBB ||
        s_axil_bvalid !== 1'b0) begin
      bad++;
      $display("FAIL bstall_second: v=%b addr=%h data=%h bvalid=%b want 1 07 bbbb 0",
               sram_wr_cmd_valid, sram_wr_cmd_addr, sram_wr_cmd_data, s_axil_bvalid);
    end
    tick();
    total++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
      bad++;
      $display("FAIL bstall_second_b: bvalid=%b bresp=%b want 1 00", s_axil_bvalid, s_axil_bresp);
    end
    tick();
  endtask

  task automatic test_range();
    sram_wr_cmd_ready = 1'b1; s_axil_bready = 1'b0;
    send_both(8'h80, 16'hC0DE, 2'b11);
    tick();
    clear_valids();
    tick();
    if (RANGE_EN) begin
      total++;
      if (sram_wr_cmd_valid !== 1'b0 || s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b10) begin
        bad++;
        $display("FAIL range_slverr: cmd_valid=%b bvalid=%b bresp=%b want 0 1 10",
                 sram_wr_cmd_valid, s_axil_bvalid, s_axil_bresp);
      end
    end else begin
      total++;
      if (sram_wr_cmd_valid !== 1'b1 || sram_wr_cmd_addr !== 7'h40) begin
        bad++;
        $display("FAIL range_trunc: cmd_valid=%b addr=%h want 1 40", sram_wr_cmd_valid, sram_wr_cmd_addr);
      end
      tick();
      total++;
      if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin
        bad++;
        $display("FAIL range_okay: bvalid=%b bresp=%b want 1 00", s_axil_bvalid, s_axil_bresp);
      end
    end
    s_axil_bready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [7:0]  a [NRAND];
    logic [15:0] d [NRAND];
    logic [1:0]  s [NRAND];
    logic [6:0]  ec_addr [$];
    logic [15:0] ec_data [$];
    logic [1:0]  ec_strb [$];
    logic [1:0]  eb [$];
    int ai = 0, wi = 0, bn = 0, cyc = 0;
    bit aw_hs, w_hs;
    for (int i = 0; i < NRAND; i++) begin
      int word;
      a[i] = 8'($urandom); d[i] = 16'($urandom); s[i] = 2'($urandom);
      word = int'(a[i]) / 2;
      if (RANGE_EN && word >= DEPTH) begin
        eb.push_back(2'b10);
      end else begin
        ec_addr.push_back(7'(word)); ec_data.push_back(d[i]); ec_strb.push_back(s[i]);
        eb.push_back(2'b00);
      end
    end
    clear_valids();
    while (bn < NRAND && cyc < 4000) begin
      if (!s_axil_awvalid && ai < NRAND && $urandom_range(0, 2) != 0) begin
        s_axil_awvalid = 1'b1; s_axil_awaddr = a[ai];
      end
      if (!s_axil_wvalid && wi < NRAND && $urandom_range(0, 2) != 0) begin
        s_axil_wvalid = 1'b1; s_axil_wdata = d[wi]; s_axil_wstrb = s[wi];
      end
      sram_wr_cmd_ready = ($urandom_range(0, 3) != 0);
      s_axil_bready = ($urandom_range(0, 3) != 0);
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs = s_axil_wvalid && s_axil_wready;
      if (sram_wr_cmd_valid && sram_wr_cmd_ready) begin
        total++;
        if (ec_addr.size() == 0) begin
          bad++;
          $display("FAIL rand_cmd_extra: addr=%h data=%h with no write expected",
                   sram_wr_cmd_addr, sram_wr_cmd_data);
        end else begin
          if (sram_wr_cmd_addr !== ec_addr[0] || sram_wr_cmd_data !== ec_data[0] ||
              sram_wr_cmd_strb !== ec_strb[0]) begin
            bad++;
            $display("FAIL rand_cmd: got %h/%h/%b want %h/%h/%b", sram_wr_cmd_addr, sram_wr_cmd_data,
                     sram_wr_cmd_strb, ec_addr[0], ec_data[0], ec_strb[0]);
          end
          void'(ec_addr.pop_front()); void'(ec_data.pop_front()); void'(ec_strb.pop_front());
        end
      end
      if (s_axil_bvalid && s_axil_bready) begin
        total++;
        if (s_axil_bresp !== eb[bn]) begin
          bad++;
          $display("FAIL rand_bresp%0d: got %b want %b", bn, s_axil_bresp, eb[bn]);
        end
        bn++;
      end
      tick();
      if (aw_hs) begin ai++; s_axil_awvalid = 1'b0; end
      if (w_hs) begin wi++; s_axil_wvalid = 1'b0; end
      cyc++;
    end
    total++;
    if (bn != NRAND || ec_addr.size() != 0) begin
      bad++;
      $display("FAIL rand_complete: responses=%0d want %0d, unissued cmds=%0d want 0",
               bn, NRAND, ec_addr.size());
    end
    clear_valids();
    sram_wr_cmd_ready = 1'b1; s_axil_bready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    sram_wr_cmd_ready = 1'b0; s_axil_bready = 1'b1;
    send_both(8'h20, 16'h1111, 2'b11);
    tick();
    clear_valids();
    tick();
    send_both(8'h22, 16'h2222, 2'b11);
    tick();
    clear_valids();
    total++;
    if (sram_wr_cmd_valid !== 1'b1 || s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pre: cmd_valid=%b awready=%b wready=%b want 1 0 0",
               sram_wr_cmd_valid, s_axil_awready, s_axil_wready);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (sram_wr_cmd_valid !== 1'b0 || s_axil_bvalid !== 1'b0 || s_axil_awready !== 1'b1 ||
        s_axil_wready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_async: cmd_valid=%b bvalid=%b awready=%b wready=%b want 0 0 1 1",
               sram_wr_cmd_valid, s_axil_bvalid, s_axil_awready, s_axil_wready);
    end
    tick();
    rst = 1'b0;
    sram_wr_cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (s_axil_bvalid !== 1'b0 || sram_wr_cmd_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_after%0d: bvalid=%b cmd_valid=%b want 0 0", i, s_axil_bvalid, sram_wr_cmd_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_cmd_stall();
    test_b_stall();
    test_range();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
